// File: rtl/kf8237_transfer_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : kf8237_common_pkg
//  Description : Shared types and helpers for the KF8237 DMA sequencer:
//                FSM state encoding, per-channel mode encodings and
//                channel-index helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package kf8237_common_pkg;

   localparam int CHANNELS = 4;
   localparam int CH_W     = 2;

   typedef enum logic [2:0] {
      ST_SI = 3'd0,
      ST_S0 = 3'd1,
      ST_S1 = 3'd2,
      ST_S2 = 3'd3,
      ST_S3 = 3'd4,
      ST_S4 = 3'd5
   } state_t;

   // Code 11 behaves exactly like single mode inside the sequencer.
   typedef enum logic [1:0] {
      MODE_DEMAND  = 2'b00,
      MODE_SINGLE  = 2'b01,
      MODE_BLOCK   = 2'b10,
      MODE_CASCADE = 2'b11
   } mode_type_t;

   // Code 11 is treated as verify: no command strobes.
   typedef enum logic [1:0] {
      XFER_VERIFY  = 2'b00,
      XFER_WRITE   = 2'b01,
      XFER_READ    = 2'b10,
      XFER_ILLEGAL = 2'b11
   } mode_transfer_t;

   function automatic logic [CH_W-1:0] onehot_to_index(input logic [CHANNELS-1:0] onehot);
      logic [CH_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (onehot[i]) idx = CH_W'(i);
      end
      return idx;
   endfunction

   function automatic logic [CHANNELS-1:0] index_to_onehot(input logic [CH_W-1:0] idx);
      return CHANNELS'(1) << idx;
   endfunction

endpackage
`default_nettype wire

// File: rtl/kf8237_transfer_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Interface   : kf8237_transfer_sequencer_if
//  Description : Request, bus-negotiation, register-file and command-strobe
//                signals of the KF8237 transfer sequencer.
//                master = sequencer side, slave = system / register-file side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface kf8237_transfer_sequencer_if;
   import kf8237_common_pkg::*;

   logic                  master_clear;
   logic [CHANNELS-1:0]   dma_request;
   logic [CHANNELS-1:0]   software_request;
   logic [CHANNELS-1:0]   channel_mask;
   logic                  rotating_priority;
   logic [2*CHANNELS-1:0] mode_type;
   logic [2*CHANNELS-1:0] mode_transfer;
   logic [CHANNELS-1:0]   autoinit_config;
   logic [CHANNELS-1:0]   decrement_config;
   logic                  hold_acknowledge;
   logic                  ready;
   logic                  end_of_process_in_n;
   logic                  underflow;

   logic                  hold_request;
   logic [CHANNELS-1:0]   dma_acknowledge;
   logic [CHANNELS-1:0]   transfer_register_select;
   logic                  next_word;
   logic                  initialize_current_register;
   logic                  decrement_address_config;
   logic                  update_high_address;
   logic                  memory_read_n;
   logic                  memory_write_n;
   logic                  io_read_n;
   logic                  io_write_n;
   logic                  end_of_process_out;
   logic [CHANNELS-1:0]   terminal_count;

   modport master (
      input  master_clear, dma_request, software_request, channel_mask,
             rotating_priority, mode_type, mode_transfer, autoinit_config,
             decrement_config, hold_acknowledge, ready, end_of_process_in_n,
             underflow,
      output hold_request, dma_acknowledge, transfer_register_select,
             next_word, initialize_current_register, decrement_address_config,
             update_high_address, memory_read_n, memory_write_n, io_read_n,
             io_write_n, end_of_process_out, terminal_count
   );

   modport slave (
      output master_clear, dma_request, software_request, channel_mask,
             rotating_priority, mode_type, mode_transfer, autoinit_config,
             decrement_config, hold_acknowledge, ready, end_of_process_in_n,
             underflow,
      input  hold_request, dma_acknowledge, transfer_register_select,
             next_word, initialize_current_register, decrement_address_config,
             update_high_address, memory_read_n, memory_write_n, io_read_n,
             io_write_n, end_of_process_out, terminal_count
   );

endinterface
`default_nettype wire

// File: rtl/kf8237_transfer_sequencer_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : kf8237_priority_arbiter
//  Description : Combinational one-hot grant among unmasked requests.
//                Fixed mode starts the search at channel 0; rotating mode
//                starts it at the priority pointer and wraps.
//  Revision    : 1.0 - initial release
// ============================================================================
module kf8237_priority_arbiter
   import kf8237_common_pkg::*;
(
   input  wire logic [CHANNELS-1:0] request,
   input  wire logic [CHANNELS-1:0] mask,
   input  wire logic [CH_W-1:0]     pointer,
   input  wire logic                rotate,
   output logic      [CHANNELS-1:0] grant
);

   logic [CH_W-1:0] w_base;
   logic [CH_W-1:0] w_idx;
   logic            w_found;

   assign w_base = rotate ? pointer : '0;

   // Walk channels from the highest-priority one; first live request wins.
   always_comb begin
      grant   = '0;
      w_found = 1'b0;
      w_idx   = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         w_idx = w_base + CH_W'(i);
         if (!w_found && request[w_idx] && !mask[w_idx]) begin
            grant[w_idx] = 1'b1;
            w_found      = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/kf8237_transfer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : kf8237_transfer_sequencer
//  Description : KF8237 DMA service sequencer. Arbitrates requests,
//                negotiates HRQ/HLDA, runs the SI/S0..S4 transfer FSM and
//                drives the register-file controls and command strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module kf8237_transfer_sequencer
   import kf8237_common_pkg::*;
(
   input  wire logic                   clock,
   input  wire logic                   reset_n,
   kf8237_transfer_sequencer_if.master bus
);

   state_t              r_state, w_next_state;
   logic [CH_W-1:0]     r_channel, w_next_channel, r_pointer, w_grant_idx;
   logic [CHANNELS-1:0] w_active, w_grant, r_dack, r_terminal_count;
   logic                r_eop_pending, r_hold_request, r_update_high_address;
   logic                r_memory_read_n, r_memory_write_n, r_io_read_n, r_io_write_n;
   logic                w_in_s4, w_tc, w_eop, w_ch_live, w_s3_next;
   mode_type_t          w_mode_type;
   mode_transfer_t      w_next_xfer;

   assign w_active    = (bus.dma_request | bus.software_request) & ~bus.channel_mask;
   assign w_ch_live   = w_active[r_channel];
   assign w_mode_type = mode_type_t'(bus.mode_type[{r_channel, 1'b0} +: 2]);
   assign w_next_xfer = mode_transfer_t'(bus.mode_transfer[{w_next_channel, 1'b0} +: 2]);
   assign w_grant_idx = onehot_to_index(w_grant);

   // An EOP seen during S1-S3 is remembered so it still terminates at S4.
   assign w_tc    = bus.underflow | ~bus.end_of_process_in_n | r_eop_pending;
   assign w_in_s4 = (r_state == ST_S4) && !bus.master_clear;
   assign w_eop   = w_in_s4 & w_tc;

   kf8237_priority_arbiter u_arbiter (
      .request (bus.dma_request | bus.software_request),
      .mask    (bus.channel_mask),
      .pointer (r_pointer),
      .rotate  (bus.rotating_priority),
      .grant   (w_grant)
   );

   // Next-state and winner selection; master_clear overrides everything.
   always_comb begin
      w_next_state   = r_state;
      w_next_channel = r_channel;
      case (r_state)
         ST_SI: if (|w_active) w_next_state = ST_S0;
         ST_S0: begin
            if (~|w_active) begin
               w_next_state = ST_SI;
            end else if (bus.hold_acknowledge) begin
               w_next_state   = ST_S1;
               w_next_channel = w_grant_idx;
            end
         end
         ST_S1: w_next_state = ST_S2;
         ST_S2: w_next_state = ST_S3;
         ST_S3: if (bus.ready) w_next_state = ST_S4;
         ST_S4: begin
            // A channel masked mid-service finishes its word, then releases the bus.
            if (w_tc || bus.channel_mask[r_channel]) begin
               w_next_state = ST_SI;
            end else begin
               case (w_mode_type)
                  MODE_BLOCK:  w_next_state = ST_S1;
                  MODE_DEMAND: w_next_state = w_ch_live ? ST_S1 : ST_SI;
                  default:     w_next_state = ST_SI;
               endcase
            end
         end
         default: w_next_state = ST_SI;
      endcase
      if (bus.master_clear) w_next_state = ST_SI;
   end

   assign w_s3_next = (w_next_state == ST_S3);

   // State, latched channel, pointer, TC status and registered outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state               <= ST_SI;
         r_channel             <= '0;
         r_pointer             <= '0;
         r_eop_pending         <= 1'b0;
         r_terminal_count      <= '0;
         r_hold_request        <= 1'b0;
         r_dack                <= '0;
         r_update_high_address <= 1'b0;
         r_memory_read_n       <= 1'b1;
         r_memory_write_n      <= 1'b1;
         r_io_read_n           <= 1'b1;
         r_io_write_n          <= 1'b1;
      end else begin
         r_state               <= w_next_state;
         r_channel             <= w_next_channel;
         r_hold_request        <= (w_next_state != ST_SI);
         r_dack                <= (w_next_state inside {ST_S1, ST_S2, ST_S3, ST_S4})
                                  ? index_to_onehot(w_next_channel) : '0;
         r_update_high_address <= (w_next_state == ST_S1);
         r_memory_read_n       <= ~(w_s3_next && w_next_xfer == XFER_READ);
         r_io_write_n          <= ~(w_s3_next && w_next_xfer == XFER_READ);
         r_io_read_n           <= ~(w_s3_next && w_next_xfer == XFER_WRITE);
         r_memory_write_n      <= ~(w_s3_next && w_next_xfer == XFER_WRITE);

         if (bus.master_clear) begin
            r_pointer        <= '0;
            r_eop_pending    <= 1'b0;
            r_terminal_count <= '0;
         end else begin
            if (r_state == ST_S4) begin
               r_eop_pending <= 1'b0;
               r_pointer     <= r_channel + 1'b1;
            end else if ((r_state inside {ST_S1, ST_S2, ST_S3}) && !bus.end_of_process_in_n) begin
               r_eop_pending <= 1'b1;
            end
            if (w_eop) r_terminal_count <= r_terminal_count | index_to_onehot(r_channel);
         end
      end
   end

   // next_word marks the final S3 cycle so underflow is ready during S4.
   assign bus.next_word                   = (r_state == ST_S3) & bus.ready & ~bus.master_clear;
   assign bus.end_of_process_out          = w_eop;
   assign bus.initialize_current_register = w_eop & bus.autoinit_config[r_channel];
   assign bus.decrement_address_config    = bus.decrement_config[r_channel];
   assign bus.hold_request                = r_hold_request;
   assign bus.dma_acknowledge             = r_dack;
   assign bus.transfer_register_select    = r_dack;
   assign bus.update_high_address         = r_update_high_address;
   assign bus.memory_read_n               = r_memory_read_n;
   assign bus.memory_write_n              = r_memory_write_n;
   assign bus.io_read_n                   = r_io_read_n;
   assign bus.io_write_n                  = r_io_write_n;
   assign bus.terminal_count              = r_terminal_count;

endmodule
`default_nettype wire
